// File: rtl/mio_pkg.sv
// mio_pkg: register map, CTRL bit positions and bus FSM encoding shared by the timer slave
package mio_pkg;
  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;
  localparam int B_EN  = 0;
  localparam int B_AR  = 1;
  localparam int B_IE  = 2;
  localparam int P_LSB = 8;
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;
  typedef struct packed {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
  } acc_t;
endpackage

// File: rtl/mio_slave_fsm.sv
// mio_slave_fsm: bus handshake IDLE/WAIT/ACK/HOLD with latched access and one-cycle ack
module mio_slave_fsm
  import mio_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        mem_w,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic        ack,
  output acc_t        acc
);
  localparam int WL = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  logic [1:0] st, nst;
  logic [2:0] wcnt;
  always_comb begin
    nst = (st == S_IDLE) ? (cs ? ((WAIT_STATES == 0) ? S_ACK : S_WAIT) : S_IDLE)
        : (st == S_WAIT) ? (!cs ? S_IDLE : (wcnt == 3'd0) ? S_ACK : S_WAIT)
        : (st == S_ACK)  ? S_HOLD
        : (cs ? S_HOLD : S_IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= S_IDLE;
      wcnt <= 3'd0;
      acc  <= '0;
    end else begin
      st   <= nst;
      wcnt <= (st == S_IDLE) ? 3'(WL) : wcnt - 3'd1;
      if (st == S_IDLE && cs)
        acc <= '{w: mem_w, a: addr, d: data_in};
    end
  end
  assign ack = (st == S_ACK);
endmodule

// File: rtl/mio_timer_slave.sv
// mio_timer_slave: memory-mapped down-counting timer with prescaler, auto-reload and level irq
module mio_timer_slave
  import mio_pkg::*;
#(
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] RESET_LOAD  = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        mem_w,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        irq,
  output logic [31:0] counter_out
);
  acc_t        acc;
  logic        ack;
  logic [31:0] ctrl, load, count, rdata;
  logic        status, en, tick, expire, wr;
  logic [7:0]  presc;
  mio_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk(clk), .rst(rst), .cs(cs), .mem_w(mem_w), .addr(addr),
    .data_in(data_in), .ack(ack), .acc(acc)
  );
  assign en     = ctrl[B_EN];
  assign tick   = en && (presc >= ctrl[P_LSB +: 8]);
  assign expire = tick && (count == 32'd0);
  assign wr     = ack && acc.w;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= 8'd0;
      ctrl   <= 32'd0;
      load   <= RESET_LOAD;
      count  <= 32'd0;
      status <= 1'b0;
    end else begin
      presc  <= (!en || tick) ? 8'd0 : presc + 8'd1;
      ctrl   <= (wr && acc.a == A_CTRL) ? (acc.d & CTRL_MASK)
              : (expire && !ctrl[B_AR]) ? (ctrl & ~32'(1 << B_EN)) : ctrl;
      load   <= (wr && acc.a == A_LOAD) ? acc.d : load;
      count  <= (wr && acc.a == A_COUNT) ? acc.d
              : !tick ? count
              : (count != 32'd0) ? count - 32'd1
              : ctrl[B_AR] ? load : 32'd0;
      status <= expire ? 1'b1 : (wr && acc.a == A_STATUS && acc.d[0]) ? 1'b0 : status;
    end
  end
  always_comb begin
    rdata = (acc.a == A_CTRL) ? ctrl
          : (acc.a == A_LOAD) ? load
          : (acc.a == A_COUNT) ? count
          : {31'd0, status};
  end
  assign data_out    = (ack && !acc.w) ? rdata : 32'd0;
  assign ready       = ack;
  assign irq         = status && ctrl[B_IE];
  assign counter_out = count;
endmodule

// File: tb/tb_mio_timer_slave.sv
// tb_mio_timer_slave: directed bus scenarios with a scoreboard checking every ready pulse
module tb_mio_timer_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        mem_w = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out, counter_out;
  logic        ready, irq;
  int          checks = 0;
  int          passes = 0;
  int          rdy_n = 0;
  int          r0, lat;
  logic [31:0] q[$];
  logic [31:0] e;
  logic [31:0] seq35 [9];
  mio_timer_slave #(.WAIT_STATES(1), .RESET_LOAD(32'h0000_FFFF)) dut (
    .clk(clk), .rst(rst), .cs(cs), .mem_w(mem_w), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ready(ready), .irq(irq), .counter_out(counter_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [31:0] exp, output int n);
    @(negedge clk);
    cs = 1'b1; mem_w = w; addr = a; data_in = d;
    q.push_back(w ? 32'd0 : exp);
    n = 1;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      $display("FAIL bus_timeout: no ready after %0d cycles, required within 20", n);
      void'(q.pop_back());
    end
    @(negedge clk);
    cs = 1'b0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int n;
    bus(1'b1, a, d, 32'd0, n);
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    int n;
    bus(1'b0, a, 32'd0, exp, n);
  endtask
  initial begin
    seq35 = '{32'd0, 32'd0, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2};
    fork
      forever begin
        @(negedge clk);
        if (ready) begin
          rdy_n++;
          if (q.size() == 0) begin
            checks++;
            $display("FAIL spurious_ready: ready=1 with data_out=%h and no access pending", data_out);
          end else begin
            e = q.pop_front();
            chk("data_out", data_out, e);
          end
        end
      end
    join_none
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_count", counter_out, 32'd0);
    rst = 1'b0;
    rd(2'd0, 32'd0);
    rd(2'd1, 32'h0000_FFFF);
    rd(2'd3, 32'd0);
    bus(1'b1, 2'd1, 32'd5, 32'd0, lat);
    chk("write_latency", 32'(lat), 32'd2);
    bus(1'b0, 2'd1, 32'd0, 32'd5, lat);
    chk("read_latency", 32'(lat), 32'd2);
    chk("data_out_hold", data_out, 32'd0);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd1);
    chk("cnt34_0", counter_out, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cnt34_seq", counter_out, 32'(2 - i));
    end
    @(negedge clk);
    chk("cnt34_stay0", counter_out, 32'd0);
    rd(2'd3, 32'd1);
    rd(2'd0, 32'd0);
    chk("irq34_masked", 32'(irq), 32'd0);
    wr(2'd3, 32'd1);
    rd(2'd3, 32'd0);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h0000_0107);
    for (int i = 0; i < 9; i++) begin
      chk("cnt35_seq", counter_out, seq35[i]);
      if (i == 1) chk("irq35_pre", 32'(irq), 32'd0);
      if (i == 2) chk("irq35_rise", 32'(irq), 32'd1);
      @(negedge clk);
    end
    wr(2'd0, 32'd0);
    wr(2'd3, 32'd1);
    rd(2'd3, 32'd0);
    rd(2'd0, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h0000_0007);
    wr(2'd3, 32'd1);
    chk("irq37_set_wins", 32'(irq), 32'd1);
    rd(2'd3, 32'd1);
    wr(2'd2, 32'd9);
    chk("cnt_bus_wins", counter_out, 32'd9);
    @(negedge clk);
    chk("cnt_after_bus", counter_out, 32'd8);
    wr(2'd0, 32'd0);
    wr(2'd3, 32'd1);
    rd(2'd3, 32'd0);
    chk("irq_cleared", 32'(irq), 32'd0);
    @(negedge clk);
    cs = 1'b1; mem_w = 1'b1; addr = 2'd1; data_in = 32'h33;
    q.push_back(32'd0);
    r0 = rdy_n;
    repeat (10) @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    chk("held_cs_readies", 32'(rdy_n - r0), 32'd1);
    rd(2'd1, 32'h33);
    @(negedge clk);
    cs = 1'b1; mem_w = 1'b1; addr = 2'd2; data_in = 32'd7;
    r0 = rdy_n;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_abort_readies", 32'(rdy_n - r0), 32'd0);
    rd(2'd2, 32'd0);
    rd(2'd1, 32'h0000_FFFF);
    @(negedge clk);
    cs = 1'b1; mem_w = 1'b1; addr = 2'd2; data_in = 32'd5;
    r0 = rdy_n;
    @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("cs_abort_readies", 32'(rdy_n - r0), 32'd0);
    rd(2'd2, 32'd0);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mio_timer_slave.md
MIO_TIMER_SLAVE -- requirements
Module: mio_timer_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning idle cycles between access accept and ready pulse (legal range 0..7).
REQ-002 SHALL have parameter RESET_LOAD, default 32'h0000_FFFF, meaning the reset value of the LOAD register.
REQ-003 SHALL have port clk, input, 1, the sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port cs, input, 1; bus chip-select from the address decoder, held high by the initiator until ready is seen.
REQ-006 SHALL have port mem_w, input, 1; 1 means write, 0 means read, sampled with cs.
REQ-007 SHALL have port addr, input, 2; word select: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS.
REQ-008 SHALL have port data_in, input, 32; write data, sampled with cs.
REQ-009 SHALL have port data_out, output, 32; read data, valid while ready=1.
REQ-010 SHALL have port ready, output, 1; one-cycle completion pulse per access (feeds CPU MIO_ready).
REQ-011 SHALL have port irq, output, 1; level interrupt, equal to STATUS[0] AND CTRL[2].
REQ-012 SHALL have port counter_out, output, 32; live COUNT value, for display.

Function
REQ-013 CTRL register SHALL have these bits: [0] enable, [1] auto-reload, [2] irq_en, [15:8] prescale divider P; all other bits read 0.
REQ-014 Bus FSM SHALL have states IDLE, WAIT, ACK and HOLD.
REQ-015 IDLE SHALL go to WAIT on cs=1 and latch mem_w, addr and data_in; if WAIT_STATES=0 it SHALL go directly to ACK.
REQ-016 WAIT SHALL last exactly WAIT_STATES cycles, then go to ACK.
REQ-017 ACK SHALL assert ready for exactly one cycle; a write SHALL commit at the end of ACK; read data SHALL be driven during ACK.
REQ-018 ACK SHALL go to HOLD; HOLD SHALL go to IDLE once cs=0, so a held cs never produces a second access.
REQ-019 Latency from cs rising to ready SHALL be WAIT_STATES+1 cycles.
REQ-020 data_out SHALL be 0 outside ACK.
REQ-021 If cs drops during WAIT, the access SHALL be aborted: return to IDLE, no commit, no ready.
REQ-022 Prescaler: while enable=1, tick SHALL pulse every P+1 cycles; the prescaler SHALL clear when enable is 0.
REQ-023 On tick with COUNT>0, COUNT SHALL decrement by 1.
REQ-024 On tick with COUNT=0: STATUS[0] SHALL be set; if auto-reload=1, COUNT SHALL be loaded from LOAD; otherwise enable SHALL clear and COUNT SHALL stay 0.
REQ-025 When a bus write to COUNT or CTRL occurs in the same cycle as a tick update, the bus write SHALL win.
REQ-026 STATUS writes SHALL be write-1-to-clear on bit 0; when clear and expiry occur in the same cycle, the set SHALL win.
REQ-027 COUNT SHALL wrap only via reload and SHALL never underflow past 0.

Reset
REQ-028 On rst, the FSM SHALL go to IDLE; ready, irq and data_out SHALL be 0.
REQ-029 On rst, CTRL SHALL be 0, LOAD SHALL be RESET_LOAD, COUNT SHALL be 0, STATUS SHALL be 0, and the prescaler SHALL be 0.
REQ-030 Reset asserted mid-access SHALL abort the access with no commit and no ready pulse.

Structure
REQ-031 The register offsets, CTRL bit positions and FSM state encoding SHALL live in shared package mio_pkg.
REQ-032 Sub-module mio_slave_fsm SHALL hold the bus handshake (IDLE/WAIT/ACK/HOLD); the timer datapath SHALL stay in the top.

Verification
REQ-033 Scenario (WAIT_STATES=1): write LOAD=5 -> ready exactly 2 cycles after cs rises; a following read of LOAD returns 32'h5.
REQ-034 Scenario: COUNT=3, P=0, enable=1, reload=0 -> COUNT reads 2,1,0; STATUS[0]=1 on the 4th tick; enable reads 0.
REQ-035 Scenario: LOAD=2, COUNT=0, P=1, enable+reload+irq_en -> irq rises after 2 cycles; COUNT sequence 2,1,0,2 with each value held 2 cycles.
REQ-036 Scenario: cs held high for 10 cycles -> exactly one ready pulse; the write commits once.
REQ-037 Scenario: write STATUS=1 in the same cycle as expiry -> STATUS[0] remains 1.
REQ-038 Scenario: rst pulsed during WAIT of a COUNT write of 7 -> no ready; COUNT reads 0 afterwards.
